// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter in front of an 8-bit JK flip-flop bank.
// One operation executes per edge; grants are one-cycle pulses after the winning edge.
module jk_bank_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [2:0] addr0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [2:0] addr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] q,
  output logic [7:0] q_,
  output logic [7:0] ops
);

  logic       gnt0_r;
  logic       gnt1_r;
  logic       last_r;
  logic [7:0] q_r;
  logic [7:0] qn_r;
  logic [7:0] ops_r;

  logic       elig0_s;
  logic       elig1_s;
  logic       win0_s;
  logic       win1_s;
  logic [1:0] op_s;
  logic [2:0] addr_s;
  logic [7:0] q_nxt_s;

  // JK next-state for one bit: {j,k} = 00 hold, 01 clear, 10 set, 11 toggle
  function automatic logic jk_next(input logic [1:0] op, input logic cur);
    logic res;
    case (op)
      2'b00:   res = cur;
      2'b01:   res = 1'b0;
      2'b10:   res = 1'b1;
      2'b11:   res = ~cur;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Eligibility and round-robin winner selection; last_r=1 favours requester 0
  always_comb begin
    elig0_s = req0 & ~gnt0_r;
    elig1_s = req1 & ~gnt1_r;
    win0_s  = elig0_s & (~elig1_s | last_r);
    win1_s  = elig1_s & (~elig0_s | ~last_r);
  end

  // Only the winner's op/addr reach the bank, so idle ports may carry anything
  always_comb begin
    q_nxt_s = q_r;
    if (win1_s) begin
      op_s   = op1;
      addr_s = addr1;
    end else begin
      op_s   = op0;
      addr_s = addr0;
    end
    if (win0_s | win1_s) begin
      q_nxt_s[addr_s] = jk_next(op_s, q_r[addr_s]);
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State update: reset dominates any concurrent request
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      last_r <= 1'b1;
      q_r    <= 8'h00;
      qn_r   <= 8'hFF;
      ops_r  <= 8'h00;
    end else begin
      gnt0_r <= win0_s;
      gnt1_r <= win1_s;
      if (win0_s | win1_s) begin
        q_r    <= q_nxt_s;
        qn_r   <= ~q_nxt_s;
        ops_r  <= ops_r + 8'd1;
        last_r <= win1_s;
      end else begin
        q_r    <= q_r;
        qn_r   <= qn_r;
        ops_r  <= ops_r;
        last_r <= last_r;
      end
    end
  end

  assign gnt0 = gnt0_r;
  assign gnt1 = gnt1_r;
  assign q    = q_r;
  assign q_   = qn_r;
  assign ops  = ops_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed vector table, wrap sequence and random
// traffic, all checked through an expectation queue against a reference model.
module tb_jk_bank_arbiter;

  typedef struct {
    logic       rst;
    logic       req0;
    logic [1:0] op0;
    logic [2:0] addr0;
    logic       req1;
    logic [1:0] op1;
    logic [2:0] addr1;
    logic       g0;
    logic       g1;
    logic [7:0] q;
    logic [7:0] ops;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
  logic       gnt0, gnt1;
  logic [7:0] q, q_, ops;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl[$];
  vec_t sb[$];

  // reference model state
  logic [7:0] m_q = 8'h00;
  logic [7:0] m_ops = 8'h00;
  logic       m_last = 1'b1;
  logic       m_g0 = 1'b0, m_g1 = 1'b0;

  jk_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0),
    .req1(req1), .op1(op1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .q(q), .q_(q_), .ops(ops)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic rq0, input logic [1:0] o0,
                             input logic [2:0] a0, input logic rq1, input logic [1:0] o1,
                             input logic [2:0] a1, input logic eg0, input logic eg1,
                             input logic [7:0] eq, input logic [7:0] eops);
    vec_t t;
    t.rst = r; t.req0 = rq0; t.op0 = o0; t.addr0 = a0;
    t.req1 = rq1; t.op1 = o1; t.addr1 = a1;
    t.g0 = eg0; t.g1 = eg1; t.q = eq; t.ops = eops;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance the model by one edge; fills expected outputs into t
  task automatic model_step(inout vec_t t);
    int         w;
    logic [1:0] o;
    logic [2:0] a;
    if (t.rst) begin
      m_q = 8'h00; m_ops = 8'h00; m_last = 1'b1; m_g0 = 1'b0; m_g1 = 1'b0;
    end else begin
      w = -1;
      if (t.req0 && !m_g0 && t.req1 && !m_g1) w = m_last ? 0 : 1;
      else if (t.req0 && !m_g0) w = 0;
      else if (t.req1 && !m_g1) w = 1;
      if (w == 0) begin o = t.op0; a = t.addr0; end
      else begin o = t.op1; a = t.addr1; end
      if (w >= 0) begin
        if (o == 2'b01) m_q[a] = 1'b0;
        else if (o == 2'b10) m_q[a] = 1'b1;
        else if (o == 2'b11) m_q[a] = !m_q[a];
        m_ops = m_ops + 8'd1;
        m_last = (w == 1);
      end
      m_g0 = (w == 0);
      m_g1 = (w == 1);
    end
    t.g0 = m_g0; t.g1 = m_g1; t.q = m_q; t.ops = m_ops;
  endtask

  // Drive one cycle, queue the expectation, compare after the edge
  task automatic run(input vec_t t, input bit use_tbl, input string tag);
    vec_t m, e;
    m = t;
    model_step(m);
    sb.push_back(use_tbl ? t : m);
    @(negedge clk);
    rst = t.rst; req0 = t.req0; op0 = t.op0; addr0 = t.addr0;
    req1 = t.req1; op1 = t.op1; addr1 = t.addr1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({tag, ".gnt0"}, {7'd0, gnt0}, {7'd0, e.g0});
    cmp({tag, ".gnt1"}, {7'd0, gnt1}, {7'd0, e.g1});
    cmp({tag, ".q"}, q, e.q);
    cmp({tag, ".q_"}, q_, ~e.q);
    cmp({tag, ".ops"}, ops, e.ops);
  endtask

  initial begin
    // single op, with X on the idle requester's op
    tbl.push_back(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0));
    tbl.push_back(v(1'b0, 1'b1, 2'b10, 3'd3, 1'b0, 2'bxx, 3'd0, 1'b1, 1'b0, 8'h08, 8'd1));
    tbl.push_back(v(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h08, 8'd1));
    // tie then alternation
    tbl.push_back(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b1, 1'b0, 8'h01, 8'd1));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b0, 1'b1, 8'h03, 8'd2));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b1, 1'b0, 8'h02, 8'd3));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b0, 1'b1, 8'h00, 8'd4));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b1, 1'b0, 8'h01, 8'd5));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd0, 1'b1, 2'b11, 3'd1, 1'b0, 1'b1, 8'h03, 8'd6));
    tbl.push_back(v(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h03, 8'd6));
    // held request: grants on edges 1, 3, 5
    tbl.push_back(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 8'h80, 8'd1));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h80, 8'd1));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 8'h00, 8'd2));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd2));
    tbl.push_back(v(1'b0, 1'b1, 2'b11, 3'd7, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 8'h80, 8'd3));
    tbl.push_back(v(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h80, 8'd3));
    // same-bit sequencing, X on the idle requester's op
    tbl.push_back(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0));
    tbl.push_back(v(1'b0, 1'b1, 2'b10, 3'd2, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 8'h04, 8'd1));
    tbl.push_back(v(1'b0, 1'b0, 2'bxx, 3'd2, 1'b1, 2'b01, 3'd2, 1'b0, 1'b1, 8'h00, 8'd2));
    // reset mid-operation, then a fresh tie goes to requester 0
    tbl.push_back(v(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 8'h01, 8'd3));
    tbl.push_back(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 2'b10, 3'd5, 1'b0, 1'b0, 8'h00, 8'd0));
    tbl.push_back(v(1'b0, 1'b1, 2'b10, 3'd1, 1'b1, 2'b10, 3'd2, 1'b1, 1'b0, 8'h02, 8'd1));
    tbl.push_back(v(1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 2'b10, 3'd2, 1'b0, 1'b1, 8'h06, 8'd2));

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // wrap: set q[6], then 256 op-00 grants with both requesters held
    run(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0), 1'b0, "wrap.rst");
    run(v(1'b0, 1'b1, 2'b10, 3'd6, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0), 1'b0, "wrap.set");
    for (int i = 0; i < 256; i++) begin
      run(v(1'b0, 1'b1, 2'b00, 3'd6, 1'b1, 2'b00, 3'd6, 1'b0, 1'b0, 8'h00, 8'd0), 1'b0,
          $sformatf("wrap%0d", i));
      if (i == 254) cmp("wrap.zero", ops, 8'h00);
    end
    cmp("wrap.q_final", q, 8'h40);
    cmp("wrap.ops_final", ops, 8'd1);

    // random traffic against the model, occasional reset
    run(v(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 8'd0), 1'b0, "rnd.rst");
    for (int i = 0; i < 200; i++) begin
      run(v(($urandom_range(19) == 0), 1'($urandom), 2'($urandom), 3'($urandom),
            1'($urandom), 2'($urandom), 3'($urandom), 1'b0, 1'b0, 8'h00, 8'd0), 1'b0,
          $sformatf("rnd%0d", i));
      if (gnt0 && gnt1) cmp("rnd.both_gnt", {6'd0, gnt0, gnt1}, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
